alu_cmd_sequencer: RTL and testbench

Byte-stream command sequencer that owns the 32-bit multi-function ALU and drives its operand and opcode inputs. It accepts a command byte plus big-endian operand bytes over a valid/ready input stream, presents them to the ALU, waits a programmable execute interval, captures the result and flags, and returns them over a valid/ready output stream. It sits between the pad-level byte interface and the ALU, replacing ad-hoc operand shift-loading with a framed, back-pressurable protocol.

---
 rtl/alu_cmd_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: framed byte-stream front end for the 32-bit ALU.
// Accepts a command byte plus big-endian operands, holds them on the ALU
// for EXEC_CYCLES, captures result/flags and streams them back out.
module alu_cmd_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_CMD,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_SEND
    } state_t;

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);
    localparam logic [4:0] OP_ILLEGAL_MIN = 5'd28;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt;
    logic [2:0]  send_idx;
    logic [3:0]  exec_cnt;
    logic [4:0]  op_q;
    logic        unary_q;
    logic        flags_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;   // doubles as the CHAIN source register
    logic [7:0]  status_q;
    logic        in_fire;
    logic        out_fire;
    logic        send_last;
    logic        exec_last;
    logic        illegal;

    // Input is only taken while framing a command, never while held in reset.
    assign in_ready  = !rst && (state_q == S_CMD || state_q == S_LOAD_A || state_q == S_LOAD_B);
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == S_SEND);
    assign out_fire  = out_valid && out_ready;
    assign send_last = (send_idx == (flags_q ? 3'd4 : 3'd3));
    assign exec_last = (exec_cnt == 4'd0);
    assign illegal   = (op_q >= OP_ILLEGAL_MIN);
    assign busy      = (state_q != S_CMD);
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) state_q <= S_CMD;
        else     state_q <= state_d;
    end

    // Next-state decode plus the output byte mux and done pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        out_data = 8'h00;
        done     = 1'b0;
        case (state_q)
            S_CMD: begin
                if (in_fire) begin
                    if (!in_data[6])     state_d = S_LOAD_A;
                    else if (!in_data[5]) state_d = S_LOAD_B;
                    else                  state_d = S_EXEC;
                end
            end
            S_LOAD_A: begin
                if (in_fire && byte_cnt == 2'd3) state_d = unary_q ? S_EXEC : S_LOAD_B;
            end
            S_LOAD_B: begin
                if (in_fire && byte_cnt == 2'd3) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_last) state_d = S_SEND;
            end
            S_SEND: begin
                case (send_idx)
                    3'd0:    out_data = result_q[31:24];
                    3'd1:    out_data = result_q[23:16];
                    3'd2:    out_data = result_q[15:8];
                    3'd3:    out_data = result_q[7:0];
                    default: out_data = status_q;
                endcase
                if (out_fire && send_last) begin
                    state_d = S_CMD;
                    done    = 1'b1;
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    // Datapath: command decode, operand shift-in, counters and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= 2'd0;
            send_idx <= 3'd0;
            exec_cnt <= 4'd0;
            op_q     <= 5'd0;
            unary_q  <= 1'b0;
            flags_q  <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            result_q <= 32'd0;
            status_q <= 8'd0;
        end else begin
            // Per-state counters restart on every state entry.
            if (state_d != state_q) begin
                byte_cnt <= 2'd0;
                send_idx <= 3'd0;
            end else begin
                if (in_fire && (state_q == S_LOAD_A || state_q == S_LOAD_B))
                    byte_cnt <= byte_cnt + 2'd1;
                if (out_fire)
                    send_idx <= send_idx + 3'd1;
            end

            if (state_d == S_EXEC && state_q != S_EXEC) exec_cnt <= EXEC_LOAD;
            else if (state_q == S_EXEC && !exec_last)   exec_cnt <= exec_cnt - 4'd1;

            if (state_q == S_CMD && in_fire) begin
                op_q    <= in_data[4:0];
                unary_q <= in_data[5];
                flags_q <= in_data[7];
                if (in_data[6]) a_q <= result_q;
                if (in_data[5]) b_q <= 32'd0;
            end

            if (state_q == S_LOAD_A && in_fire) a_q <= {a_q[23:0], in_data};
            if (state_q == S_LOAD_B && in_fire) b_q <= {b_q[23:0], in_data};

            if (state_q == S_EXEC && exec_last) begin
                result_q <= illegal ? 32'd0 : alu_result;
                status_q <= {illegal, 3'b000, alu_flags};
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed tests of the command sequencer with a
// behavioural ALU attached to its operand/opcode outputs.
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        busy, done;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ADD=0, SUB=1, INC=4, NOT=19, everything else yields 0.
    always_comb begin
        logic [32:0] w;
        logic        c, v;
        w = 33'd0;
        c = 1'b0;
        v = 1'b0;
        case (alu_op)
            5'd0: begin
                w = {1'b0, alu_a} + {1'b0, alu_b};
                c = w[32];
                v = (alu_a[31] == alu_b[31]) && (w[31] != alu_a[31]);
            end
            5'd1: begin
                w = {1'b0, alu_a} - {1'b0, alu_b};
                c = (alu_a >= alu_b);
                v = (alu_a[31] != alu_b[31]) && (w[31] != alu_a[31]);
            end
            5'd4: begin
                w = {1'b0, alu_a} + 33'd1;
                c = w[32];
                v = !alu_a[31] && w[31];
            end
            5'd19: w = {1'b0, ~alu_a};
            default: w = 33'd0;
        endcase
        alu_result = w[31:0];
        alu_flags  = {(w[31:0] == 32'd0), c, v, w[31]};
    end

    // Offer one byte and hold it until the DUT takes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
        end
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] tmp;
        tmp = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(tmp[31:24]);
            tmp = tmp << 8;
        end
    endtask

    // Wait for an output byte, accept it, check value and done pulse.
    task automatic recv_byte(input logic [7:0] exp, input logic last, input string name);
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (t >= 50) begin
            errors++;
            $display("FAIL %s_timeout out_valid=%0b required 1", name, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_data !== exp) begin
            errors++;
            $display("FAIL %s out_data=%h required %h", name, out_data, exp);
        end
        checks++;
        if (done !== last) begin
            errors++;
            $display("FAIL %s_done done=%0b required %0b", name, done, last);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s busy=%0b out_valid=%0b in_ready=%0b required 0 0 1",
                     name, busy, out_valid, in_ready);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL reset_values in_ready=%0b out_valid=%0b out_data=%h busy=%0b done=%0b a=%h b=%h op=%h required all zero",
                     in_ready, out_valid, out_data, busy, done, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_idle("reset_release");
    endtask

    task automatic test_add;
        int lat;
        send_byte(8'h80);
        send_word(32'h0000_0005);
        send_word(32'h0000_0003);
        // Last B byte accepted on the edge just passed: EXEC now, SEND next cycle.
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL add_exec out_valid=%0b in_ready=%0b busy=%0b required 0 0 1",
                     out_valid, in_ready, busy);
        end
        checks++;
        if (alu_a !== 32'h5 || alu_b !== 32'h3 || alu_op !== 5'd0) begin
            errors++;
            $display("FAIL add_operands a=%h b=%h op=%h required 5 3 0", alu_a, alu_b, alu_op);
        end
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL add_latency cycles=%0d required 2", lat);
        end
        recv_byte(8'h00, 1'b0, "add_b0");
        recv_byte(8'h00, 1'b0, "add_b1");
        recv_byte(8'h00, 1'b0, "add_b2");
        recv_byte(8'h08, 1'b0, "add_b3");
        recv_byte(8'h00, 1'b1, "add_status");
        expect_idle("add_after");
    endtask

    task automatic test_chain;
        send_byte(8'h64);
        checks++;
        if (in_ready !== 1'b0 || alu_a !== 32'h8 || alu_b !== 32'h0 || alu_op !== 5'd4) begin
            errors++;
            $display("FAIL chain_operands in_ready=%0b a=%h b=%h op=%h required 0 8 0 4",
                     in_ready, alu_a, alu_b, alu_op);
        end
        recv_byte(8'h00, 1'b0, "chain_b0");
        recv_byte(8'h00, 1'b0, "chain_b1");
        recv_byte(8'h00, 1'b0, "chain_b2");
        recv_byte(8'h09, 1'b1, "chain_b3");
        expect_idle("chain_after");
    endtask

    task automatic test_sub;
        send_byte(8'h81);
        send_word(32'h0000_0003);
        send_word(32'h0000_0005);
        recv_byte(8'hFF, 1'b0, "sub_b0");
        recv_byte(8'hFF, 1'b0, "sub_b1");
        recv_byte(8'hFF, 1'b0, "sub_b2");
        recv_byte(8'hFE, 1'b0, "sub_b3");
        recv_byte(8'h01, 1'b1, "sub_status");
        expect_idle("sub_after");
    endtask

    task automatic test_not_unary;
        send_byte(8'h33);
        send_word(32'h0F0F_0F0F);
        checks++;
        if (in_ready !== 1'b0 || alu_b !== 32'd0 || alu_a !== 32'h0F0F_0F0F) begin
            errors++;
            $display("FAIL not_unary in_ready=%0b a=%h b=%h required 0 0f0f0f0f 0",
                     in_ready, alu_a, alu_b);
        end
        recv_byte(8'hF0, 1'b0, "not_b0");
        recv_byte(8'hF0, 1'b0, "not_b1");
        recv_byte(8'hF0, 1'b0, "not_b2");
        recv_byte(8'hF0, 1'b1, "not_b3");
        expect_idle("not_after");
    endtask

    task automatic test_illegal_backpressure;
        send_byte(8'h9C);
        send_word(32'h1234_5678);
        send_word(32'h1234_5678);
        recv_byte(8'h00, 1'b0, "ill_b0");
        recv_byte(8'h00, 1'b0, "ill_b1");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h00 || done !== 1'b0) begin
                errors++;
                $display("FAIL ill_stall%0d out_valid=%0b out_data=%h done=%0b required 1 00 0",
                         i, out_valid, out_data, done);
            end
        end
        recv_byte(8'h00, 1'b0, "ill_b2");
        recv_byte(8'h00, 1'b0, "ill_b3");
        recv_byte(8'h88, 1'b1, "ill_status");
        expect_idle("ill_after");
    endtask

    task automatic test_reset_mid_op;
        send_byte(8'h80);
        send_word(32'h0000_0007);
        send_byte(8'h00);
        send_byte(8'h00);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
            in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset busy=%0b out_valid=%0b a=%h b=%h in_ready=%0b done=%0b required 0 0 0 0 0 0",
                     busy, out_valid, alu_a, alu_b, in_ready, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        expect_idle("mid_reset_release");
        send_byte(8'h80);
        send_word(32'h0000_0001);
        send_word(32'h0000_0001);
        recv_byte(8'h00, 1'b0, "rec_b0");
        recv_byte(8'h00, 1'b0, "rec_b1");
        recv_byte(8'h00, 1'b0, "rec_b2");
        recv_byte(8'h02, 1'b0, "rec_b3");
        recv_byte(8'h00, 1'b1, "rec_status");
        expect_idle("rec_after");
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_sub();
        test_not_unary();
        test_illegal_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
